// File: rtl/bw_io_misc_pad_ctl_if.sv
// Core-side pad bank bus: requests and raw pad inputs into the controller,
// registered pad drives, filtered inputs and hold-off status out of it.
interface bw_io_misc_pad_ctl_if #(
    parameter int NCH = 2
);
    logic [NCH-1:0] oe_req;
    logic [NCH-1:0] data_out;
    logic [NCH-1:0] pad_in;
    logic [NCH-1:0] pad_oe;
    logic [NCH-1:0] pad_data;
    logic [NCH-1:0] core_in;
    logic [NCH-1:0] core_in_chg;
    logic           oe_ready;

    modport master (
        output oe_req, data_out, pad_in,
        input  pad_oe, pad_data, core_in, core_in_chg, oe_ready
    );

    modport slave (
        input  oe_req, data_out, pad_in,
        output pad_oe, pad_data, core_in, core_in_chg, oe_ready
    );
endinterface

// File: rtl/bw_io_misc_pad_ctl.sv
// Misc CMOS pad bank controller: output-enable hold-off after reset/POR,
// registered pad drive, and synchronised glitch-filtered pad inputs.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_HOLD  | hold-off counting, all pad_oe forced low
//   ST_READY | hold-off done, oe_req passed through to pad_oe
module bw_io_misc_pad_ctl #(
    parameter int NCH     = 2,
    parameter int FILT_W  = 4,
    parameter int HOLDOFF = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              por_l,
    input  logic [FILT_W-1:0] filt_thresh,
    bw_io_misc_pad_ctl_if.slave bus
);

    typedef enum logic {ST_HOLD, ST_READY} state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] hcnt;
    logic [15:0] hcnt_nxt;
    logic        oe_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HOLD;
            hcnt  <= '0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
        end
    end

    // por_l low acts as a soft reset of the sequencer only
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        if (!por_l) begin
            state_nxt = ST_HOLD;
            hcnt_nxt  = '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (hcnt == HOLD_LAST) begin
                        state_nxt = ST_READY;
                        hcnt_nxt  = '0;
                    end else begin
                        hcnt_nxt = hcnt + 16'd1;
                    end
                end
                ST_READY: hcnt_nxt = '0;
                default: begin
                    state_nxt = ST_HOLD;
                    hcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_comb begin
        oe_ready = (state == ST_READY);
    end

    logic [NCH-1:0] pad_oe_r;
    logic [NCH-1:0] pad_data_r;

    // oe_ready here is the value before this edge's sequencer update
    always_ff @(posedge clk) begin
        if (rst) begin
            pad_oe_r   <= '0;
            pad_data_r <= '0;
        end else begin
            pad_oe_r   <= {NCH{oe_ready & por_l}} & bus.oe_req;
            pad_data_r <= bus.data_out;
        end
    end

    logic [NCH-1:0]    s1;
    logic [NCH-1:0]    s2;
    logic [NCH-1:0]    core_in_r;
    logic [NCH-1:0]    chg_r;
    logic [FILT_W-1:0] fcnt [NCH];
    logic [FILT_W-1:0] thr_m1;

    // a threshold of 0 behaves as 1
    assign thr_m1 = (filt_thresh == '0) ? '0 : filt_thresh - 1'b1;

    // >= lets a lowered threshold accept on the very next mismatching cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            core_in_r <= '0;
            chg_r     <= '0;
            for (int i = 0; i < NCH; i++) fcnt[i] <= '0;
        end else begin
            s1 <= bus.pad_in;
            s2 <= s1;
            for (int i = 0; i < NCH; i++) begin
                chg_r[i] <= 1'b0;
                if (s2[i] == core_in_r[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] >= thr_m1) begin
                    core_in_r[i] <= s2[i];
                    chg_r[i]     <= 1'b1;
                    fcnt[i]      <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.pad_oe      = pad_oe_r;
    assign bus.pad_data    = pad_data_r;
    assign bus.core_in     = core_in_r;
    assign bus.core_in_chg = chg_r;
    assign bus.oe_ready    = oe_ready;

endmodule

// File: tb/tb_bw_io_misc_pad_ctl.sv
// Scoreboard bench for bw_io_misc_pad_ctl: directed hold-off/POR/filter
// sequences followed by randomized traffic against a behavioural model.
module tb_bw_io_misc_pad_ctl;

    localparam int NCH     = 8;
    localparam int FILT_W  = 4;
    localparam int HOLDOFF = 16;

    typedef struct packed {
        logic [NCH-1:0] oe;
        logic [NCH-1:0] data;
        logic [NCH-1:0] cin;
        logic [NCH-1:0] chg;
        logic           rdy;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              por_l;
    logic [FILT_W-1:0] ft;

    bw_io_misc_pad_ctl_if #(.NCH(NCH)) bus ();

    bw_io_misc_pad_ctl #(.NCH(NCH), .FILT_W(FILT_W), .HOLDOFF(HOLDOFF)) dut (
        .clk         (clk),
        .rst         (rst),
        .por_l       (por_l),
        .filt_thresh (ft),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    // behavioural model: counts cycles since release, and how long the
    // synchronised input has disagreed with the accepted value
    logic [NCH-1:0] m_s1, m_s2, m_core, m_chg, m_oe, m_data;
    int             m_run [NCH];
    int             m_cnt;
    bit             m_rdy;

    task automatic model_step();
        int   thr;
        exp_t e;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_core = '0; m_chg = '0; m_oe = '0; m_data = '0;
            for (int c = 0; c < NCH; c++) m_run[c] = 0;
            m_cnt = 0;
            m_rdy = 0;
        end else begin
            thr    = (ft == 0) ? 1 : int'(ft);
            m_oe   = (m_rdy && por_l) ? bus.oe_req : '0;
            m_data = bus.data_out;
            if (!por_l) begin
                m_cnt = 0;
                m_rdy = 0;
            end else begin
                m_cnt++;
                if (m_cnt >= HOLDOFF) m_rdy = 1;
            end
            for (int c = 0; c < NCH; c++) begin
                m_chg[c] = 1'b0;
                if (m_s2[c] != m_core[c]) begin
                    m_run[c]++;
                    if (m_run[c] >= thr) begin
                        m_core[c] = m_s2[c];
                        m_chg[c]  = 1'b1;
                        m_run[c]  = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = bus.pad_in;
        end
        e.oe = m_oe; e.data = m_data; e.cin = m_core; e.chg = m_chg; e.rdy = m_rdy;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic p, input logic [NCH-1:0] oe,
                        input logic [NCH-1:0] d, input logic [NCH-1:0] pin,
                        input logic [FILT_W-1:0] t);
        rst = r; por_l = p; bus.oe_req = oe; bus.data_out = d; bus.pad_in = pin; ft = t;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("pad_oe",      bus.pad_oe,      e.oe);
            chk("pad_data",    bus.pad_data,    e.data);
            chk("core_in",     bus.core_in,     e.cin);
            chk("core_in_chg", bus.core_in_chg, e.chg);
            chk("oe_ready",    {{(NCH-1){1'b0}}, bus.oe_ready}, {{(NCH-1){1'b0}}, e.rdy});
        end
    end

    initial begin
        logic [NCH-1:0] pin;
        logic [NCH-1:0] flip;
        logic           p;
        logic           r;
        int             first_rdy;

        rst = 1'b1; por_l = 1'b1; ft = 4'd4;
        bus.oe_req = '0; bus.data_out = '0; bus.pad_in = '0;

        repeat (3) step(1'b1, 1'b1, '1, NCH'($urandom), '0, 4'd4);

        // hold-off: oe_ready must first read high after the 16th edge
        first_rdy = -1;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b1, '1, NCH'($urandom), '0, 4'd4);
            if (first_rdy < 0 && bus.oe_ready === 1'b1) first_rdy = k;
        end
        n_checks++;
        if (first_rdy != HOLDOFF - 1) begin
            n_fail++;
            $display("FAIL holdoff_latency: got edge %0d expected edge %0d", first_rdy, HOLDOFF - 1);
        end

        // filter accept on channel 0
        repeat (10) step(1'b0, 1'b1, '1, NCH'($urandom), 8'h01, 4'd4);
        // 3-cycle glitch on channel 1, then a 4-cycle pulse that is accepted
        repeat (3)  step(1'b0, 1'b1, '1, NCH'($urandom), 8'h03, 4'd4);
        repeat (8)  step(1'b0, 1'b1, '1, NCH'($urandom), 8'h01, 4'd4);
        repeat (4)  step(1'b0, 1'b1, '1, NCH'($urandom), 8'h03, 4'd4);
        repeat (10) step(1'b0, 1'b1, '1, NCH'($urandom), 8'h01, 4'd4);
        // threshold 0 with a one-cycle alternating input
        for (int k = 0; k < 12; k++)
            step(1'b0, 1'b1, '1, NCH'($urandom), (k % 2 == 0) ? 8'h00 : 8'h01, 4'd0);
        repeat (5) step(1'b0, 1'b1, '1, NCH'($urandom), 8'h00, 4'd0);
        // POR pulse while ready
        repeat (3)  step(1'b0, 1'b0, 8'h03, NCH'($urandom), 8'h02, 4'd2);
        repeat (22) step(1'b0, 1'b1, 8'h03, NCH'($urandom), 8'h02, 4'd2);

        pin = 8'h02;
        ft  = 4'd3;
        for (int k = 0; k < 10000; k++) begin
            flip = '0;
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 5) == 0) flip[c] = 1'b1;
            pin = pin ^ flip;
            if (k % 500 == 0) ft = 4'($urandom_range(0, 6));
            p = ($urandom_range(0, 199) != 0);
            r = ($urandom_range(0, 999) == 0);
            step(r, p, NCH'($urandom), NCH'($urandom), pin, ft);
        end

        for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bw_io_misc_pad_ctl.md
# bw_io_misc_pad_ctl

Parametrised core-side controller for a bank of NCH bidirectional miscellaneous CMOS pads, such as the PMI/PMO monitor pins. It sits between core logic and the bw_io_cmos2_pad instances. On the output side it holds pad output-enables off for a fixed hold-off after reset or power-on-reset, then registers data and enable. On the input side it synchronises each pad's to_core signal and glitch-filters it, and reports filtered edges to the core.

## Interface
Parameters:
- NCH, 2: number of pad channels (1..32).
- FILT_W, 4: width of the glitch-filter counter and of filt_thresh.
- HOLDOFF, 16: cycles after reset or por_l release before any pad_oe may assert (2..2^16-1).

Ports:
- clk  in  1  core clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- por_l  in  1  power-on reset, active-low, already synchronous to clk; low acts as a soft reset of the output path only.
- oe_req  in  NCH  per-channel output-enable request from core.
- data_out  in  NCH  per-channel data to drive.
- filt_thresh  in  FILT_W  stable-cycle count required to accept an input change; 0 is treated as 1; quasi-static.
- pad_in  in  NCH  raw to_core from pads; asynchronous.
- pad_oe  out  NCH  registered output-enable to pads.
- pad_data  out  NCH  registered data to pads.
- core_in  out  NCH  synchronised, filtered pad value.
- core_in_chg  out  NCH  one-cycle pulse when core_in changes.
- oe_ready  out  1  hold-off complete; oe_req is honoured.

## Operation
Hold-off sequencer: two states, HOLD and READY, with a 16-bit counter hcnt.
- rst, or por_l low: state goes to HOLD, hcnt to 0, oe_ready to 0.
- In HOLD, hcnt increments each cycle. The cycle in which hcnt == HOLDOFF-1, state goes to READY and oe_ready to 1.
- READY persists until rst or por_l low.

Output path, per channel:
- pad_oe[i] <= oe_ready & por_l & oe_req[i]. The registered oe_ready (pre-update value) is used.
- pad_data[i] <= data_out[i] every cycle. Data is not gated by OE.

Input path, per channel:
- Two-flop synchroniser: s1 <= pad_in, s2 <= s1.
- Filter counter fcnt[i], FILT_W bits. Let thr = max(filt_thresh, 1).
- If s2 == core_in: fcnt <= 0.
- Else if fcnt == thr-1: core_in <= s2, fcnt <= 0, core_in_chg <= 1.
- Else: fcnt <= fcnt+1.
- core_in_chg is 0 in every other cycle.
- A pulse shorter than thr cycles at s2 never reaches core_in. The counter restarts on any return to the old value.
- The input path runs regardless of pad_oe, so driven values read back through the filter. por_l does not affect the input path.
- A change to filt_thresh mid-count takes effect immediately. If fcnt is already >= thr-1, the next mismatching cycle accepts.

## Timing
- Reset values, applied at the first clk edge with rst high: pad_oe 0, pad_data 0, core_in 0, core_in_chg 0, oe_ready 0. s1, s2, fcnt and hcnt are all 0.
- Hold-off: with rst deasserted before edge 0, oe_ready is high after edge HOLDOFF-1. The earliest pad_oe is high after edge HOLDOFF.
- oe_req/data_out to pad_oe/pad_data: 1 cycle.
- por_l falling: pad_oe is 0 after the next edge, for all channels, the same edge on which oe_ready clears. Hold-off restarts when por_l returns high.
- pad_in change stable before edge 0: s2 updates at edge 1, core_in and the core_in_chg pulse at edge 1+thr.
- Simultaneous rst and por_l low: rst dominates. The result is identical because both clear the sequencer.
- Channels are independent, and multiple core_in_chg bits may pulse in the same cycle.

## Test plan
- Reset/hold-off: HOLDOFF=16, oe_req all 1 from reset release. pad_oe stays 0 through edge 15, oe_ready rises after edge 15, and pad_oe = all 1 after edge 16.
- POR mid-operation: in READY with oe_req=2'b11, drive por_l low for 3 cycles. pad_oe goes 0 on the next edge, and oe_ready reasserts HOLDOFF edges after por_l returns high. core_in is unaffected.
- Filter accept: filt_thresh=4, pad_in[0] goes 0→1 and is held. core_in[0] rises at edge 5, core_in_chg[0] pulses for exactly one cycle, and channel 1 is unchanged.
- Glitch reject: filt_thresh=4, pad_in[1] high for 3 cycles then low. core_in[1] stays 0 and core_in_chg[1] never pulses. Also check that a 4-cycle pulse is accepted and then de-asserts 4 cycles after it falls.
- Threshold 0: filt_thresh=0, toggle pad_in[0]. It behaves as thr=1, with core_in following 2 edges after the change. Alternating pattern 1,0 with one-cycle periods: core_in follows s2 delayed by one edge.
- Width scaling: NCH=8 with random oe_req/data_out/pad_in against a reference model for 10k cycles. Every bit matches, including simultaneous core_in_chg pulses.
